// File: rtl/mem_arbiter.sv
// Two-way arbiter sharing the unified memory port between instruction fetch (IF)
// and load/store (LS). LS has priority, bounded by an IF anti-starvation counter.
// Responses are registered one cycle after grant; misaligned accesses are
// consumed without a memory access and answered with err=1.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch requester
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    // load/store requester
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    // memory port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // STARVE_MAX is limited to 1..15, so a 4-bit saturating counter suffices
    localparam int unsigned   CNT_W      = 4;
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             if_aligned;
    logic             ls_aligned;

    assign if_aligned = (if_addr[1:0] == 2'b00);
    assign ls_aligned = (ls_addr[1:0] == 2'b00);

    // Grant selection: LS first unless IF has waited STARVE_MAX LS grants
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (!rst) begin
            if (ls_req && (!if_req || (starve_cnt < STARVE_LIM))) begin
                ls_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    // Memory port drive; misaligned or idle cycles leave the port fully quiet
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ls_gnt && ls_aligned) begin
            mem_en    = 1'b1;
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end else if (if_gnt && if_aligned) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr;
            mem_wdata = ls_wdata;
        end
    end

    // Anti-starvation counter: counts LS wins while IF is waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (if_gnt || !if_req) begin
            starve_cnt <= '0;
        end else if (ls_gnt && (starve_cnt != CNT_SAT)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // IF response register; data/err hold while rvalid is low
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
        end else begin
            if_rvalid <= if_gnt;
            if (if_gnt) begin
                if_err   <= !if_aligned;
                if_rdata <= if_aligned ? mem_rdata : '0;
            end
        end
    end

    // LS response register; stores and misaligned accesses return zero data
    always_ff @(posedge clk) begin
        if (rst) begin
            ls_rvalid <= 1'b0;
            ls_err    <= 1'b0;
            ls_rdata  <= '0;
        end else begin
            ls_rvalid <= ls_gnt;
            if (ls_gnt) begin
                ls_err   <= !ls_aligned;
                ls_rdata <= (ls_aligned && !ls_we) ? mem_rdata : '0;
            end
        end
    end

endmodule
